// File: rtl/ctrl_decode_pipe.sv
// MIPS control decoder behind a one-entry registered output stage with flush and an illegal counter.
// Define CTRL_EXT_OPS_EN to decode slti and lui; otherwise those opcodes are treated as illegal.
module ctrl_decode_pipe #(
  parameter int ALUCTL_W = 4,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [PC_W-1:0]     in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic                RegWrite,
  output logic                MemtoReg,
  output logic                MemWrite,
  output logic                Branch,
  output logic                ALUSrc,
  output logic                ALUSrc_shamt,
  output logic                RegDst,
  output logic                Link,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                illegal,
  output logic [CNT_W-1:0]    illegal_cnt
);

  localparam logic [3:0] ALU_ILLEGAL = 4'b1011;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic branch;
    logic alu_src;
    logic alu_src_shamt;
    logic reg_dst;
    logic link;
  } ctrl_t;

  ctrl_t            dec_ctrl, ctrl_q, ctrl_gated;
  logic [3:0]       dec_alu, alu_q;
  logic             dec_illegal, illegal_q;
  logic             valid_q, accept;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       op, funct;
  logic             unused_fields;

  assign op            = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    dec_ctrl    = '0;
    dec_alu     = ALU_ILLEGAL;
    dec_illegal = 1'b0;
    case (op)
      6'h00: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.reg_dst   = 1'b1;
        case (funct)
          6'h20, 6'h21: dec_alu = 4'b0010;
          6'h22, 6'h23: dec_alu = 4'b0110;
          6'h24:        dec_alu = 4'b0000;
          6'h25:        dec_alu = 4'b0001;
          6'h26:        dec_alu = 4'b0011;
          6'h27:        dec_alu = 4'b1100;
          6'h2A:        dec_alu = 4'b0111;
          6'h04:        dec_alu = 4'b0100;
          6'h06:        dec_alu = 4'b0101;
          6'h07:        dec_alu = 4'b1000;
          6'h00: begin dec_alu = 4'b0100; dec_ctrl.alu_src_shamt = 1'b1; end
          6'h02: begin dec_alu = 4'b0101; dec_ctrl.alu_src_shamt = 1'b1; end
          6'h03: begin dec_alu = 4'b1000; dec_ctrl.alu_src_shamt = 1'b1; end
          // jr only redirects the PC, so it must not write the register file
          6'h08: begin dec_alu = 4'b1110; dec_ctrl = '0; end
          default: begin dec_ctrl = '0; dec_illegal = 1'b1; end
        endcase
      end
      6'h08, 6'h09: begin dec_alu = 4'b0010; dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_src = 1'b1; end
      6'h0C: begin dec_alu = 4'b0000; dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_src = 1'b1; end
      6'h0D: begin dec_alu = 4'b0001; dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_src = 1'b1; end
      6'h0E: begin dec_alu = 4'b0011; dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_src = 1'b1; end
      6'h23: begin
        dec_alu             = 4'b0010;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
      end
      6'h2B: begin dec_alu = 4'b0010; dec_ctrl.mem_write = 1'b1; dec_ctrl.alu_src = 1'b1; end
      6'h04: begin dec_alu = 4'b1001; dec_ctrl.branch = 1'b1; end
      6'h05: begin dec_alu = 4'b1010; dec_ctrl.branch = 1'b1; end
      6'h02: dec_alu = 4'b1101;
      6'h03: begin dec_alu = 4'b1101; dec_ctrl.link = 1'b1; dec_ctrl.reg_write = 1'b1; end
`ifdef CTRL_EXT_OPS_EN
      6'h0A: begin dec_alu = 4'b0111; dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_src = 1'b1; end
      6'h0F: begin dec_alu = 4'b1111; dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_src = 1'b1; end
`endif
      default: dec_illegal = 1'b1;
    endcase
  end

  assign in_ready = (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // flush wins over everything; accept already excludes flush so counting stays consistent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      ctrl_q    <= '0;
      alu_q     <= ALU_ILLEGAL;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (flush)          valid_q <= 1'b0;
      else if (accept)    valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;
      if (accept) begin
        pc_q      <= in_pc;
        ctrl_q    <= dec_ctrl;
        alu_q     <= dec_alu;
        illegal_q <= dec_illegal;
      end
      if (accept && dec_illegal && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Bubbles present a harmless bundle so nothing downstream writes state
  assign ctrl_gated  = valid_q ? ctrl_q : '0;
  assign {RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUSrc_shamt, RegDst, Link} = ctrl_gated;
  assign ALUControl  = ALUCTL_W'(valid_q ? alu_q : ALU_ILLEGAL);
  assign illegal     = valid_q && illegal_q;
  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Self-checking bench for ctrl_decode_pipe: directed steps plus random traffic against a table-driven model.
module tb_ctrl_decode_pipe;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic        RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUSrc_shamt, RegDst, Link;
  logic [3:0]  ALUControl;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  int errors = 0;
  int checks = 0;

  ctrl_decode_pipe #(.ALUCTL_W(4), .PC_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .Branch(Branch), .ALUSrc(ALUSrc), .ALUSrc_shamt(ALUSrc_shamt),
    .RegDst(RegDst), .Link(Link), .ALUControl(ALUControl), .illegal(illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 if (clk_en) clk = ~clk;

  // bits: {RegWrite,MemtoReg,MemWrite,Branch,ALUSrc,ALUSrc_shamt,RegDst,Link}
  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    bit         rtype;
    logic [3:0] alu;
    logic [7:0] bits;
  } entry_t;

  entry_t tbl[$];

  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pc = 32'h0;
  int          m_cnt = 0;

  task automatic addEntry(input logic [5:0] op, input logic [5:0] funct, input bit rtype,
                          input logic [3:0] alu, input logic [7:0] bits);
    entry_t e;
    e.op = op; e.funct = funct; e.rtype = rtype; e.alu = alu; e.bits = bits;
    tbl.push_back(e);
  endtask

  task automatic buildTable();
    addEntry(6'h00, 6'h20, 1, 4'b0010, 8'h82); addEntry(6'h00, 6'h21, 1, 4'b0010, 8'h82);
    addEntry(6'h00, 6'h22, 1, 4'b0110, 8'h82); addEntry(6'h00, 6'h23, 1, 4'b0110, 8'h82);
    addEntry(6'h00, 6'h24, 1, 4'b0000, 8'h82); addEntry(6'h00, 6'h25, 1, 4'b0001, 8'h82);
    addEntry(6'h00, 6'h26, 1, 4'b0011, 8'h82); addEntry(6'h00, 6'h27, 1, 4'b1100, 8'h82);
    addEntry(6'h00, 6'h2A, 1, 4'b0111, 8'h82); addEntry(6'h00, 6'h04, 1, 4'b0100, 8'h82);
    addEntry(6'h00, 6'h06, 1, 4'b0101, 8'h82); addEntry(6'h00, 6'h07, 1, 4'b1000, 8'h82);
    addEntry(6'h00, 6'h00, 1, 4'b0100, 8'h86); addEntry(6'h00, 6'h02, 1, 4'b0101, 8'h86);
    addEntry(6'h00, 6'h03, 1, 4'b1000, 8'h86); addEntry(6'h00, 6'h08, 1, 4'b1110, 8'h00);
    addEntry(6'h08, 6'h00, 0, 4'b0010, 8'h88); addEntry(6'h09, 6'h00, 0, 4'b0010, 8'h88);
    addEntry(6'h0C, 6'h00, 0, 4'b0000, 8'h88); addEntry(6'h0D, 6'h00, 0, 4'b0001, 8'h88);
    addEntry(6'h0E, 6'h00, 0, 4'b0011, 8'h88); addEntry(6'h23, 6'h00, 0, 4'b0010, 8'hC8);
    addEntry(6'h2B, 6'h00, 0, 4'b0010, 8'h28); addEntry(6'h04, 6'h00, 0, 4'b1001, 8'h10);
    addEntry(6'h05, 6'h00, 0, 4'b1010, 8'h10); addEntry(6'h02, 6'h00, 0, 4'b1101, 8'h00);
    addEntry(6'h03, 6'h00, 0, 4'b1101, 8'h81);
`ifdef CTRL_EXT_OPS_EN
    addEntry(6'h0A, 6'h00, 0, 4'b0111, 8'h88); addEntry(6'h0F, 6'h00, 0, 4'b1111, 8'h88);
`endif
  endtask

  function automatic void refDecode(input logic [31:0] ins, output logic [3:0] alu,
                                    output logic [7:0] bits, output logic ill);
    alu = 4'b1011; bits = 8'h00; ill = 1'b1;
    foreach (tbl[i])
      if (tbl[i].op == ins[31:26] && (!tbl[i].rtype || tbl[i].funct == ins[5:0])) begin
        alu = tbl[i].alu; bits = tbl[i].bits; ill = 1'b0;
      end
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] a;
    logic [7:0] b;
    logic       il;
    refDecode(m_instr, a, b, il);
    if (!m_valid) begin a = 4'b1011; b = 8'h00; il = 1'b0; end
    checkVal("out_valid", out_valid, m_valid);
    checkVal("ALUControl", ALUControl, a);
    checkVal("ctrl_bits", {RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUSrc_shamt, RegDst, Link}, b);
    checkVal("illegal", illegal, il);
    checkVal("illegal_cnt", illegal_cnt, m_cnt);
    checkVal("out_pc", out_pc, m_pc);
  endtask

  task automatic modelUpdate();
    logic [3:0] a;
    logic [7:0] b;
    logic       il;
    logic       rdy;
    rdy = (!m_valid || out_ready) && !flush;
    if (flush) m_valid = 1'b0;
    else if (in_valid && rdy) begin
      refDecode(instr, a, b, il);
      m_valid = 1'b1; m_instr = instr; m_pc = in_pc;
      if (il && m_cnt < 255) m_cnt++;
    end else if (out_ready) m_valid = 1'b0;
  endtask

  // Called at a falling edge: drive, check in_ready, clock once, check the held bundle
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic fl, input logic ordy);
    in_valid = v; instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
    #1;
    checkVal("in_ready", in_ready, (!m_valid || ordy) && !fl);
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    checkOutput();
  endtask

  function automatic logic [31:0] randomInstr();
    int k;
    if ($urandom_range(0, 9) < 7) begin
      k = $urandom_range(0, tbl.size() - 1);
      if (tbl[k].rtype) return {6'h00, 20'($urandom), tbl[k].funct};
      return {tbl[k].op, 26'($urandom)};
    end
    return $urandom;
  endfunction

  initial begin
    buildTable();

    // Reset with the clock stopped
    instr = 32'h00221820; in_valid = 1'b1; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput();
    checkVal("rst_aluctl_const", ALUControl, 4'b1011);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1 clk_en = 1'b1;
    @(negedge clk);

    // add $3,$1,$2
    applyStimulus(1, 32'h00221820, 32'h100, 0, 1);
    checkVal("add_aluctl_const", ALUControl, 4'b0010);
    checkVal("add_bits_const", {RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUSrc_shamt, RegDst, Link}, 8'h82);
    applyStimulus(0, 32'h0, 32'h0, 0, 1);

    // lw, sw, beq with downstream stalled for three cycles
    applyStimulus(1, 32'h8C220004, 32'h200, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'hAC220008, 32'h204, 0, 0);
    applyStimulus(1, 32'hAC220008, 32'h204, 0, 1);
    applyStimulus(1, 32'h10220003, 32'h208, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 1);

    // flush while a bundle is held and a new one is offered
    applyStimulus(1, 32'h00221822, 32'h300, 0, 0);
    applyStimulus(1, 32'h00221824, 32'h304, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 1);

    // slti and lui
    applyStimulus(1, 32'h2822000A, 32'h400, 0, 1);
    applyStimulus(1, 32'h3C011234, 32'h404, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 1);

    // random traffic
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, randomInstr(), $urandom,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);

    // reset mid-transfer discards the held bundle
    applyStimulus(1, 32'h00221820, 32'h500, 0, 0);
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0; m_pc = 32'h0; m_cnt = 0;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 32'h00221825, 32'h600, 0, 1);

    // counter saturation
    for (int i = 0; i < 300; i++) applyStimulus(1, 32'hFC000000, 32'h700 + i, 0, 1);
    checkVal("sat_cnt_const", illegal_cnt, 8'd255);
    checkVal("sat_illegal_const", illegal, 1'b1);
    applyStimulus(0, 32'h0, 32'h0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
